// File: rtl/hpm_pkg.sv
// Shared constants and types for the hardware performance-monitor counter bank.
// Counter slots are numbered by their bit position in mcountinhibit/ovf/ovf_en.
package hpm_pkg;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MHPM_BASE     = 12'hB03;
  localparam logic [11:0] ADDR_MHPMH_BASE    = 12'hB83;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_OVF           = 12'h7C0;
  localparam logic [11:0] ADDR_OVF_EN        = 12'h7C1;

  localparam int IDX_CYCLE    = 0;
  localparam int IDX_INSTRET  = 2;
  localparam int IDX_EVT_BASE = 3;

  typedef struct packed {
    logic       valid;
    logic       hi;
    logic [4:0] idx;
  } cnt_slot_t;

  // Counter CSRs sit at 0xB00+idx (lo) and 0xB80+idx (hi); slot 1 does not exist.
  function automatic cnt_slot_t decode_counter(input logic [11:0] addr, input int num_evt);
    cnt_slot_t s;
    s.hi    = addr[7];
    s.idx   = addr[4:0];
    s.valid = (addr[11:8] == 4'hB) && (addr[6:5] == 2'b00) && (addr[4:0] != 5'd1) &&
              (int'({27'd0, addr[4:0]}) <= num_evt + IDX_INSTRET);
    return s;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One CNT_W-bit performance counter with half-word CSR writes and a wrap pulse.
// Any write to either half suppresses the increment for that cycle.
module hpm_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value,
  output logic             wrap
);

  logic do_inc;

  assign do_inc = inc & ~inhibit & ~we_lo & ~we_hi;
  assign wrap   = do_inc & (&value);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (we_lo) begin
      value[31:0] <= wdata;
    end else if (we_hi) begin
      value[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (do_inc) begin
      value <= value + 1'b1;
    end
  end

  if (CNT_W < 64) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^wdata[31:CNT_W-32];
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// mcycle, minstret and NUM_EVT event counters with inhibit, sticky overflow
// and a registered one-cycle-latency CSR read port.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instret_en,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               csr_re,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_rvalid,
  output logic               csr_hit,
  output logic               ovf_irq
);

  localparam logic [63:0] SPAN     = (64'd1 << (NUM_EVT + 3)) - 64'd1;
  localparam logic [31:0] CSR_MASK = SPAN[31:0] & 32'hFFFF_FFFD;

  logic [31:0]      inhibit, ovf, ovf_en, wrap;
  logic [31:0]      we_lo, we_hi;
  logic [CNT_W-1:0] cnt_val [32];
  logic [63:0]      ext;
  logic [31:0]      rd_next;
  cnt_slot_t        slot;
  logic             hit_inh, hit_ovf, hit_ovf_en;

  assign slot       = decode_counter(csr_addr, NUM_EVT);
  assign hit_inh    = (csr_addr == ADDR_MCOUNTINHIBIT);
  assign hit_ovf    = (csr_addr == ADDR_OVF);
  assign hit_ovf_en = (csr_addr == ADDR_OVF_EN);
  assign csr_hit    = slot.valid | hit_inh | hit_ovf | hit_ovf_en;
  assign ovf_irq    = |(ovf & ovf_en);

  always_comb begin
    we_lo = '0;
    we_hi = '0;
    if (csr_we && slot.valid) begin
      if (slot.hi) we_hi[slot.idx] = 1'b1;
      else         we_lo[slot.idx] = 1'b1;
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_slot
    if (k != 1 && k <= NUM_EVT + IDX_INSTRET) begin : g_cnt
      logic inc;
      if (k == IDX_CYCLE) begin : g_cyc
        assign inc = 1'b1;
      end else if (k == IDX_INSTRET) begin : g_ins
        assign inc = instret_en;
      end else begin : g_evt
        assign inc = evt_i[k-IDX_EVT_BASE];
      end
      hpm_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .inhibit(inhibit[k]),
        .we_lo  (we_lo[k]),
        .we_hi  (we_hi[k]),
        .wdata  (csr_wdata),
        .value  (cnt_val[k]),
        .wrap   (wrap[k])
      );
    end else begin : g_none
      assign cnt_val[k] = '0;
      assign wrap[k]    = 1'b0;
    end
  end

  // A wrap in the same cycle as a W1C clear leaves the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inhibit <= '0;
      ovf     <= '0;
      ovf_en  <= '0;
    end else begin
      if (csr_we && hit_inh)    inhibit <= csr_wdata & CSR_MASK;
      if (csr_we && hit_ovf_en) ovf_en  <= csr_wdata & CSR_MASK;
      ovf <= ((csr_we && hit_ovf) ? (ovf & ~csr_wdata) : ovf) | (wrap & CSR_MASK);
    end
  end

  always_comb begin
    ext     = 64'(cnt_val[slot.idx]);
    rd_next = '0;
    if (slot.valid)      rd_next = slot.hi ? ext[63:32] : ext[31:0];
    else if (hit_inh)    rd_next = inhibit;
    else if (hit_ovf)    rd_next = ovf;
    else if (hit_ovf_en) rd_next = ovf_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_re;
      if (csr_re) csr_rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomized and directed stimulus for hpm_counter_bank, checked by a
// scoreboard against an arithmetic reference model of the counter CSRs.
module tb_hpm_counter_bank;

  localparam int NE = 4;
  localparam int CW = 40;
  localparam logic [63:0] MAXV = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instret_en = 1'b0;
  logic [NE-1:0] evt_i = '0;
  logic          csr_re = 1'b0;
  logic          csr_we = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid;
  logic          csr_hit;
  logic          ovf_irq;

  always #5 clk = ~clk;

  hpm_counter_bank #(.NUM_EVT(NE), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .instret_en(instret_en),
    .evt_i     (evt_i),
    .csr_re    (csr_re),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_rvalid(csr_rvalid),
    .csr_hit   (csr_hit),
    .ovf_irq   (ovf_irq)
  );

  logic [63:0] m_cnt [32];
  logic [31:0] m_inh, m_ovf, m_oven, valid_mask;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic [11:0] addr_pool [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 32; j++) m_cnt[j] = '0;
    m_inh  = '0;
    m_ovf  = '0;
    m_oven = '0;
  endtask

  // Counter number addressed by a, or -1 if a is not a counter CSR.
  function automatic int cnt_index(input logic [11:0] a);
    int off;
    if (a < 12'hB00 || a > 12'hB9F) return -1;
    off = (a >= 12'hB80) ? int'(a) - 'hB80 : int'(a) - 'hB00;
    if (off == 1 || off > NE + 2) return -1;
    return off;
  endfunction

  function automatic logic model_hit(input logic [11:0] a);
    return (cnt_index(a) >= 0) || a == 12'h320 || a == 12'h7C0 || a == 12'h7C1;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int k;
    logic [63:0] sh;
    k = cnt_index(a);
    if (k >= 0) begin
      sh = (a >= 12'hB80) ? (m_cnt[k] >> 32) : m_cnt[k];
      return sh[31:0];
    end
    if (a == 12'h320) return m_inh;
    if (a == 12'h7C0) return m_ovf;
    if (a == 12'h7C1) return m_oven;
    return 32'h0;
  endfunction

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cyc(input bit re, input bit we, input logic [11:0] addr,
                     input logic [31:0] wd, input bit ins, input logic [NE-1:0] ev);
    int k;
    bit hi;
    logic [31:0] req, wraps, nov;
    csr_re = re; csr_we = we; csr_addr = addr; csr_wdata = wd;
    instret_en = ins; evt_i = ev;
    #1;
    check("csr_hit", 32'(csr_hit), 32'(model_hit(addr)));
    if (re) exp_q.push_back(model_read(addr));
    k     = cnt_index(addr);
    hi    = (addr >= 12'hB80);
    req   = 32'd1 | (32'(ins) << 2) | (32'(ev) << 3);
    wraps = '0;
    for (int j = 0; j < 32; j++) begin
      if (!valid_mask[j]) continue;
      if (we && k == j) begin
        if (hi) m_cnt[j] = ({wd, 32'h0} | (m_cnt[j] & 64'hFFFF_FFFF)) & MAXV;
        else    m_cnt[j] = (m_cnt[j] & ~64'hFFFF_FFFF) | {32'h0, wd};
      end else if (req[j] && !m_inh[j]) begin
        if (m_cnt[j] == MAXV) begin
          m_cnt[j] = '0;
          wraps[j] = 1'b1;
        end else begin
          m_cnt[j] = m_cnt[j] + 64'd1;
        end
      end
    end
    nov = m_ovf;
    if (we && addr == 12'h7C0) nov = nov & ~wd;
    m_ovf = nov | wraps;
    if (we && addr == 12'h320) m_inh  = wd & valid_mask;
    if (we && addr == 12'h7C1) m_oven = wd & valid_mask;
    @(posedge clk);
    @(negedge clk);
    check("ovf_irq", 32'(ovf_irq), 32'(|(m_ovf & m_oven)));
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0, '0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (csr_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=0x%08h expected no read at %0t",
                 csr_rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("csr_rdata", csr_rdata, mon_exp);
      end
    end
  end

  initial begin
    valid_mask = 32'h1;
    for (int j = 2; j <= NE + 2; j++) valid_mask[j] = 1'b1;
    model_reset();
    for (int j = 0; j <= NE + 2; j++) begin
      addr_pool.push_back(12'(12'hB00 + j));
      addr_pool.push_back(12'(12'hB80 + j));
    end
    addr_pool.push_back(12'h320);
    addr_pool.push_back(12'h7C0);
    addr_pool.push_back(12'h7C1);
    addr_pool.push_back(12'hB87);
    addr_pool.push_back(12'h000);

    #1;
    check("reset_rdata", csr_rdata, 32'h0);
    check("reset_rvalid", 32'(csr_rvalid), 32'h0);
    check("reset_irq", 32'(ovf_irq), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    repeat (10) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, '0);
    rd(12'hB00);
    rd(12'hB02);

    wr(12'h7C1, 32'h1);
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    repeat (2) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, '0);
    rd(12'hB00);
    rd(12'h7C0);
    wr(12'h7C0, 32'h1);
    rd(12'h7C0);

    wr(12'h320, 32'h8);
    repeat (5) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 4'b0001);
    rd(12'hB03);
    wr(12'h320, 32'h0);
    repeat (5) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 4'b0001);
    rd(12'hB03);

    cyc(1'b0, 1'b1, 12'hB02, 32'h100, 1'b1, '0);
    rd(12'hB02);

    wr(12'hB82, 32'hFFFF_FFFF);
    rd(12'hB82);
    rd(12'hB80);
    cyc(1'b1, 1'b1, 12'hB00, 32'h1234_5678, 1'b1, 4'b1111);
    rd(12'hB00);
    rd(12'h123);
    rd(12'hB01);
    rd(12'hB87);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320);
    wr(12'h320, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      bit re, we;
      a  = addr_pool[$urandom_range(addr_pool.size() - 1)];
      re = ($urandom_range(1) == 1);
      we = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: d = $urandom;
      endcase
      if (a == 12'h320) d = d & 32'h0000_00F0;
      cyc(re, we, a, d, 1'($urandom_range(1)), NE'($urandom));
    end

    rst = 1'b1;
    csr_re = 1'b1; csr_we = 1'b0; csr_addr = 12'hB00;
    #2 rst = 1'b0;
    #1;
    check("midrst_rdata", csr_rdata, 32'h0);
    check("midrst_rvalid", 32'(csr_rvalid), 32'h0);
    check("midrst_irq", 32'(ovf_irq), 32'h0);
    csr_re = 1'b0;
    @(negedge clk);
    check("midrst_no_rvalid", 32'(csr_rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    rd(12'hB00);
    rd(12'hB00);
    rd(12'hB02);
    rd(12'h7C0);
    rd(12'hB83);

    repeat (2) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, '0);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_rvalid: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
